// File: rtl/u_game_judge_disp_ctrl_if.sv
// Judgment event input and display output bundle for the judge display controller.
interface u_game_judge_disp_ctrl_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             i_judge_vld;
  logic [1:0]       i_judge;
  logic             i_clr;
  logic [1:0]       o_judge;
  logic             o_busy;
  logic [CNT_W-1:0] o_cnt;
  logic             o_ovf;

  modport master (
    output i_judge_vld, i_judge, i_clr,
    input  o_judge, o_busy, o_cnt, o_ovf
  );

  modport slave (
    input  i_judge_vld, i_judge, i_clr,
    output o_judge, o_busy, o_cnt, o_ovf
  );
endinterface

// File: rtl/u_game_judge_disp_ctrl.sv
// Queues judgment events and shows each on the judge display for a fixed
// hold time, followed by a blank gap, strictly in arrival order.
module u_game_judge_disp_ctrl #(
  parameter int unsigned HOLD_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 2_500_000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  u_game_judge_disp_ctrl_if.slave   bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned HG_MAX  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned TMR_MAX = (HG_MAX > 2) ? HG_MAX : 2;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned HOLD_LD = HOLD_CYC - 1;
  localparam int unsigned GAP_LD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [1:0]         judge_q, judge_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         mem_q [DEPTH];

  logic evt, full, push, drop, pop;

  // Full/empty decisions use pre-edge occupancy so a same-edge pop never frees a slot.
  always_comb begin
    evt  = bus.i_judge_vld && (bus.i_judge != 2'b00) && !bus.i_clr;
    full = (occ_q == CNT_W'(DEPTH));
    push = evt && !full;
    drop = evt && full;
    pop  = (state_q == ST_IDLE) && (occ_q != '0) && !bus.i_clr;
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    judge_d  = judge_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    if (drop) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        judge_d = 2'b00;
        busy_d  = 1'b0;
        if (pop) begin
          judge_d = mem_q[rd_ptr_q];
          tmr_d   = TMR_W'(HOLD_LD);
          busy_d  = 1'b1;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (tmr_q == '0) begin
          judge_d = 2'b00;
          if (GAP_CYC > 0) begin
            tmr_d   = TMR_W'(GAP_LD);
            state_d = ST_GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        judge_d = 2'b00;
        if (tmr_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        judge_d = 2'b00;
        busy_d  = 1'b0;
        tmr_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Flush aborts any show/gap and discards both queue and the same-cycle event.
    if (bus.i_clr) begin
      state_d  = ST_IDLE;
      tmr_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      judge_d  = 2'b00;
      busy_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      judge_q  <= 2'b00;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      judge_q  <= judge_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Queue storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= bus.i_judge;
  end

  assign bus.o_judge = judge_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_cnt   = occ_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_u_game_judge_disp_ctrl.sv
// Directed bench for the judge display controller with HOLD_CYC=4, GAP_CYC=2, DEPTH=4.
module tb_u_game_judge_disp_ctrl;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  u_game_judge_disp_ctrl_if #(.DEPTH(DEPTH)) bus ();

  u_game_judge_disp_ctrl #(
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] code, input logic clr);
    bus.i_judge_vld = vld;
    bus.i_judge     = code;
    bus.i_clr       = clr;
  endtask

  task automatic chk_out(input string tag, input int j, input int b, input int c);
    chk({tag, ".judge"}, int'(bus.o_judge), j);
    chk({tag, ".busy"},  int'(bus.o_busy),  b);
    chk({tag, ".cnt"},   int'(bus.o_cnt),   c);
  endtask

  initial begin
    logic [1:0] ovf_codes [6];
    n_tests = 0;
    n_fail  = 0;
    ovf_codes[0] = 2'b11; ovf_codes[1] = 2'b10; ovf_codes[2] = 2'b01;
    ovf_codes[3] = 2'b11; ovf_codes[4] = 2'b10; ovf_codes[5] = 2'b01;

    // Reset with a simultaneous strobe: reset wins.
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b0);
    step();
    step();
    chk_out("rst", 0, 0, 0);
    chk("rst.ovf", int'(bus.o_ovf), 0);

    // Single event on first edge after reset.
    rst = 1'b0;
    drive(1'b1, 2'b11, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("single.e0", 0, 0, 1);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk_out($sformatf("single.e%0d", e), 3, 1, 0);
    end
    for (int e = 5; e <= 6; e++) begin
      step();
      chk_out($sformatf("single.e%0d", e), 0, 1, 0);
    end
    step();
    chk_out("single.e7", 0, 0, 0);

    // Back-to-back: 10 then 01; push and pop collide at edge 1.
    drive(1'b1, 2'b10, 1'b0);
    step();
    chk_out("b2b.e0", 0, 0, 1);
    drive(1'b1, 2'b01, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("b2b.e1", 2, 1, 1);
    for (int e = 2; e <= 4; e++) begin
      step();
      chk_out($sformatf("b2b.e%0d", e), 2, 1, 1);
    end
    for (int e = 5; e <= 6; e++) begin
      step();
      chk_out($sformatf("b2b.e%0d", e), 0, 1, 1);
    end
    step();
    chk_out("b2b.e7", 0, 0, 1);
    for (int e = 8; e <= 11; e++) begin
      step();
      chk_out($sformatf("b2b.e%0d", e), 1, 1, 0);
    end
    for (int e = 12; e <= 14; e++) step();
    chk_out("b2b.e14", 0, 0, 0);

    // Overflow: six strobes, the sixth is dropped.
    for (int e = 0; e <= 5; e++) begin
      drive(1'b1, ovf_codes[e], 1'b0);
      step();
    end
    drive(1'b0, 2'b00, 1'b0);
    chk_out("ovf.e5", 0, 1, 4);
    chk("ovf.e5.ovf", int'(bus.o_ovf), 1);
    step();
    step();
    chk_out("ovf.e7", 0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out($sformatf("ovf.show%0d", k), int'(ovf_codes[k+1]), 1, 3 - k);
      for (int s = 0; s < 6; s++) step();
    end
    chk_out("ovf.end", 0, 0, 0);
    chk("ovf.sticky", int'(bus.o_ovf), 1);

    // IDLE code strobe changes nothing.
    drive(1'b1, 2'b00, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("idlecode.e0", 0, 0, 0);
    chk("idlecode.ovf", int'(bus.o_ovf), 1);
    step();
    chk_out("idlecode.e1", 0, 0, 0);

    // Clear mid-show with two queued, plus a strobe on the clear edge.
    drive(1'b1, 2'b11, 1'b0); step();
    drive(1'b1, 2'b10, 1'b0); step();
    drive(1'b1, 2'b01, 1'b0); step();
    chk_out("clr.pre", 3, 1, 2);
    drive(1'b1, 2'b11, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("clr.post", 0, 0, 0);
    chk("clr.ovf", int'(bus.o_ovf), 0);
    drive(1'b1, 2'b10, 1'b0);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("clr.next.e0", 0, 0, 1);
    step();
    chk_out("clr.next.e1", 2, 1, 0);

    // Clear mid-gap.
    for (int s = 0; s < 4; s++) step();
    chk_out("clrgap.pre", 0, 1, 0);
    drive(1'b0, 2'b00, 1'b1);
    step();
    drive(1'b0, 2'b00, 1'b0);
    chk_out("clrgap.post", 0, 0, 0);

    // Reset with queued work and a same-edge strobe.
    drive(1'b1, 2'b01, 1'b0);
    step();
    chk_out("rst2.pre", 0, 0, 1);
    rst = 1'b1;
    drive(1'b1, 2'b11, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    chk_out("rst2.post", 0, 0, 0);
    step();
    chk_out("rst2.idle", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
